// File: rtl/mult_div_unit.sv
// Sequential signed multiply/divide unit: WIDTH-cycle radix-2 Booth
// multiply and restoring divide, results in HI/LO, one-cycle Done.
// Optional macro MDU_FAST_MULT_EN: single-cycle combinational multiply.
// Ports: clk, reset (async active-low), MultStart/DivStart strobes,
//   A/B operands, Busy/Done/DivZero status, Hi/Lo result registers.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MultStart,
    input  logic             DivStart,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MULT,
        S_DIV,
        S_DONE
    } state_t;

    localparam logic [5:0] LAST = 6'(WIDTH - 1);

    state_t state, state_nx;

    logic [5:0]       cnt;
    logic [WIDTH:0]   acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic             q_m1;
    logic [WIDTH-1:0] opb;
    logic             sign_a;
    logic             sign_b;
    logic             dz;

    logic             b_zero;
    logic             last;
    logic [WIDTH:0]   mcand_x;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   m_hi_n;
    logic [WIDTH-1:0] m_lo_n;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   d_hi_n;
    logic [WIDTH-1:0] d_lo_n;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;

`ifdef MDU_FAST_MULT_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = $signed({{WIDTH{A[WIDTH-1]}}, A})
                     * $signed({{WIDTH{B[WIDTH-1]}}, B});
`endif

    assign b_zero  = (B == '0);
    assign last    = (cnt == LAST);
    assign Busy    = (state == S_MULT) || (state == S_DIV);
    assign Done    = (state == S_DONE);
    assign DivZero = dz;

    // Booth step: hi carries one guard bit so that subtracting the most
    // negative multiplicand cannot overflow before the arithmetic shift.
    always_comb begin
        mcand_x = {opb[WIDTH-1], opb};
        case ({acc_lo[0], q_m1})
            2'b01:   booth_sum = acc_hi + mcand_x;
            2'b10:   booth_sum = acc_hi - mcand_x;
            default: booth_sum = acc_hi;
        endcase
        m_hi_n = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        m_lo_n = {booth_sum[0], acc_lo[WIDTH-1:1]};
    end

    // Restoring step on magnitudes: acc_hi is the partial remainder,
    // acc_lo shifts the dividend out and the quotient bits in.
    always_comb begin
        r_sh = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
        diff = r_sh - {1'b0, opb};
        if (!diff[WIDTH]) begin
            d_hi_n = diff;
            d_lo_n = {acc_lo[WIDTH-2:0], 1'b1};
        end else begin
            d_hi_n = r_sh;
            d_lo_n = {acc_lo[WIDTH-2:0], 1'b0};
        end
        quo = (sign_a ^ sign_b) ? -d_lo_n : d_lo_n;
        rem = sign_a ? -d_hi_n[WIDTH-1:0] : d_hi_n[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // MultStart has priority over DivStart when both are asserted.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (MultStart) begin
`ifdef MDU_FAST_MULT_EN
                    state_nx = S_DONE;
`else
                    state_nx = S_MULT;
`endif
                end else if (DivStart) begin
                    state_nx = b_zero ? S_DONE : S_DIV;
                end
            end
            S_MULT, S_DIV: begin
                if (last) state_nx = S_DONE;
            end
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            q_m1   <= 1'b0;
            opb    <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            dz     <= 1'b0;
            Hi     <= '0;
            Lo     <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    cnt <= '0;
                    dz  <= 1'b0;
                    if (MultStart) begin
`ifdef MDU_FAST_MULT_EN
                        Hi <= fast_prod[2*WIDTH-1:WIDTH];
                        Lo <= fast_prod[WIDTH-1:0];
`else
                        acc_hi <= '0;
                        acc_lo <= B;
                        q_m1   <= 1'b0;
                        opb    <= A;
`endif
                    end else if (DivStart) begin
                        if (b_zero) begin
                            dz <= 1'b1;
                        end else begin
                            acc_hi <= '0;
                            acc_lo <= A[WIDTH-1] ? -A : A;
                            opb    <= B[WIDTH-1] ? -B : B;
                            sign_a <= A[WIDTH-1];
                            sign_b <= B[WIDTH-1];
                        end
                    end
                end
                S_MULT: begin
                    cnt    <= cnt + 6'd1;
                    acc_hi <= m_hi_n;
                    acc_lo <= m_lo_n;
                    q_m1   <= acc_lo[0];
                    if (last) begin
                        Hi <= m_hi_n[WIDTH-1:0];
                        Lo <= m_lo_n;
                    end
                end
                S_DIV: begin
                    cnt    <= cnt + 6'd1;
                    acc_hi <= d_hi_n;
                    acc_lo <= d_lo_n;
                    if (last) begin
                        Hi <= rem;
                        Lo <= quo;
                    end
                end
                S_DONE: begin
                    dz <= 1'b0;
                end
                default: begin
                    dz <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table, arbitration,
// reset-abort and random ops checked through an expected-result queue.
module tb_mult_div_unit;

    localparam int W = 32;
`ifdef MDU_FAST_MULT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    typedef struct {
        logic        mul;
        logic        div;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          MultStart = 1'b0;
    logic          DivStart = 1'b0;
    logic [W-1:0]  A = '0;
    logic [W-1:0]  B = '0;
    logic          Busy;
    logic          Done;
    logic          DivZero;
    logic [W-1:0]  Hi;
    logic [W-1:0]  Lo;

    exp_t        sb[$];
    vec_t        tv[15];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .MultStart(MultStart),
        .DivStart (DivStart),
        .A        (A),
        .B        (B),
        .Busy     (Busy),
        .Done     (Done),
        .DivZero  (DivZero),
        .Hi       (Hi),
        .Lo       (Lo)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_op(input logic mul, input logic div,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edz);
        exp_t e;
        int   n;
        int   busy;
        e.hi  = ehi;
        e.lo  = elo;
        e.dz  = edz;
        e.lat = (edz || (mul && FAST)) ? 0 : W;
        sb.push_back(e);
        MultStart = mul;
        DivStart  = div;
        A = a;
        B = b;
        @(posedge clk); #1;
        MultStart = 1'b0;
        DivStart  = 1'b0;
        A = $urandom;
        B = $urandom;
        n = 0;
        busy = 0;
        while (!Done && n < 100) begin
            if (Busy) busy++;
            @(posedge clk); #1;
            n++;
        end
        e = sb.pop_front();
        chk("done_seen", 64'(Done), 64'(1));
        chk("latency", 64'(n), 64'(e.lat));
        chk("busy_cycles", 64'(busy), 64'(e.lat));
        chk("busy_at_done", 64'(Busy), 64'(0));
        chk("hi", 64'(Hi), 64'(e.hi));
        chk("lo", 64'(Lo), 64'(e.lo));
        chk("divzero", 64'(DivZero), 64'(e.dz));
        @(posedge clk); #1;
        chk("done_pulse", 64'(Done), 64'(0));
        chk("divzero_pulse", 64'(DivZero), 64'(0));
        chk("hi_hold", 64'(Hi), 64'(e.hi));
        chk("lo_hold", 64'(Lo), 64'(e.lo));
        m_hi = e.hi;
        m_lo = e.lo;
    endtask

    initial begin
        int          dones;
        int          dzseen;
        int          sa;
        int          sbv;
        longint      p;
        logic        mul;
        logic [31:0] a;
        logic [31:0] b;
        exp_t        e;

        tv[0]  = '{1'b1, 1'b0, 32'd7, 32'hFFFFFFFD,
                   32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        tv[1]  = '{1'b0, 1'b1, 32'hFFFFFFF9, 32'd2,
                   32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        tv[2]  = '{1'b0, 1'b1, 32'd7, 32'hFFFFFFFE,
                   32'd1, 32'hFFFFFFFD, 1'b0};
        tv[3]  = '{1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF,
                   32'd0, 32'h80000000, 1'b0};
        tv[4]  = '{1'b1, 1'b1, 32'd3, 32'd4,
                   32'd0, 32'd12, 1'b0};
        tv[5]  = '{1'b1, 1'b0, 32'h80000000, 32'h80000000,
                   32'h40000000, 32'd0, 1'b0};
        tv[6]  = '{1'b1, 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF,
                   32'h3FFFFFFF, 32'd1, 1'b0};
        tv[7]  = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                   32'd0, 32'd1, 1'b0};
        tv[8]  = '{1'b0, 1'b1, 32'd100, 32'd7,
                   32'd2, 32'd14, 1'b0};
        tv[9]  = '{1'b0, 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9,
                   32'hFFFFFFFE, 32'd14, 1'b0};
        tv[10] = '{1'b0, 1'b1, 32'd3, 32'd5,
                   32'd3, 32'd0, 1'b0};
        tv[11] = '{1'b0, 1'b1, 32'h451, 32'h20,
                   32'h11, 32'h22, 1'b0};
        tv[12] = '{1'b0, 1'b1, 32'd5, 32'd0,
                   32'h11, 32'h22, 1'b1};
        tv[13] = '{1'b1, 1'b0, 32'h12345678, 32'd0,
                   32'd0, 32'd0, 1'b0};
        tv[14] = '{1'b1, 1'b0, 32'h80000000, 32'h7FFFFFFF,
                   32'hC0000000, 32'h80000000, 1'b0};

        // reset state
        #12;
        chk("rst_busy", 64'(Busy), 64'(0));
        chk("rst_done", 64'(Done), 64'(0));
        chk("rst_divzero", 64'(DivZero), 64'(0));
        chk("rst_hi", 64'(Hi), 64'(0));
        chk("rst_lo", 64'(Lo), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) begin
            run_op(tv[i].mul, tv[i].div, tv[i].a, tv[i].b,
                   tv[i].hi, tv[i].lo, tv[i].dz);
        end

        // strobes mid-operation and during DONE must be ignored
        e.hi  = 32'd0;
        e.lo  = 32'd12;
        e.dz  = 1'b0;
        e.lat = 0;
        sb.push_back(e);
        MultStart = 1'b1;
        A = 32'd3;
        B = 32'd4;
        @(posedge clk); #1;
        MultStart = 1'b0;
        dones  = 0;
        dzseen = 0;
        for (int c = 0; c <= 60; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            MultStart = 1'b0;
            DivStart  = (c == 10) && !FAST;
            if (c == 10) B = 32'd0;
            if (DivZero) dzseen++;
            if (Done) begin
                dones++;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("arb_hi", 64'(Hi), 64'(e.hi));
                    chk("arb_lo", 64'(Lo), 64'(e.lo));
                end
                MultStart = 1'b1;
            end
        end
        MultStart = 1'b0;
        DivStart  = 1'b0;
        chk("arb_done_count", 64'(dones), 64'(1));
        chk("arb_divzero_seen", 64'(dzseen), 64'(0));
        m_hi = 32'd0;
        m_lo = 32'd12;

        // random ops against a behavioural model
        for (int i = 0; i < 16; i++) begin
            mul = 1'($urandom_range(0, 1));
            a = $urandom;
            b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
            sa  = a;
            sbv = b;
            if (mul) begin
                p = longint'(sa) * longint'(sbv);
                run_op(1'b1, 1'b0, a, b, p[63:32], p[31:0], 1'b0);
            end else if (b == 32'd0) begin
                run_op(1'b0, 1'b1, a, b, m_hi, m_lo, 1'b1);
            end else begin
                run_op(1'b0, 1'b1, a, b, 32'(sa % sbv), 32'(sa / sbv),
                       1'b0);
            end
        end

        // reset in the middle of a multiply
        run_op(1'b1, 1'b0, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0);
        MultStart = 1'b1;
        A = 32'd9;
        B = 32'd11;
        @(posedge clk); #1;
        MultStart = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        reset = 1'b0;
        #1;
        chk("abort_busy", 64'(Busy), 64'(0));
        chk("abort_done", 64'(Done), 64'(0));
        chk("abort_hi", 64'(Hi), 64'(0));
        chk("abort_lo", 64'(Lo), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        dones = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (Done) dones++;
        end
        chk("abort_no_done", 64'(dones), 64'(0));
        chk("sb_empty", 64'(sb.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
